// File: rtl/fft_pkg.sv
// Shared constants for the fft sample-load link: default frame geometry and
// the receiver FSM state encoding.
package fft_pkg;

  localparam int FFT_N   = 32;  // words per frame (power of 2)
  localparam int FFT_MSB = 16;  // bits per word

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECV    = 2'd1;
  localparam logic [1:0] ST_WAIT_CS = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RECV    = ST_RECV,
    WAIT_CS = ST_WAIT_CS
  } rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI line, followed by a delay
// stage so that single-cycle rise/fall strobes can be derived in clk domain.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  // Synchroniser chain plus edge-detect delay; all stages share the reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      dly  <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~dly;
  assign fall  = dly & ~sync;

endmodule

// File: rtl/fft_spi_in.sv
// SPI mode-0 slave receiver: reassembles MSB-first words of a cs-framed burst
// and presents them on the fft sample-load interface.
//
// Output handshake: insert_data is a one-cycle strobe with no back-pressure;
// addr/data_out are valid in the strobe cycle and hold until the next strobe.
// frame_done coincides with the strobe of word N-1; frame_err is a lone pulse.
module fft_spi_in
  import fft_pkg::*;
#(
  parameter int N   = FFT_N,
  parameter int MSB = FFT_MSB
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs,
  output logic                 insert_data,
  output logic [$clog2(N)-1:0] addr,
  output logic [MSB-1:0]       data_out,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int AW = $clog2(N);
  localparam int BW = $clog2(MSB);

  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic cs_s, cs_rise, cs_fall;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );
  // cs resets "asserted" so a cs held low through reset never opens a frame.
  spi_sync #(.RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  rx_state_t      state, state_nxt;
  logic [BW-1:0]  bit_cnt;
  logic [AW-1:0]  word_cnt;
  logic [MSB-1:0] shift;

  logic word_done;   // this cycle's sclk edge completes a word
  logic last_word;   // the completed word is word N-1
  logic abort;       // cs released before the frame completed

  assign word_done = (state == RECV) && sclk_rise && (bit_cnt == BW'(MSB-1));
  assign last_word = word_done && (word_cnt == AW'(N-1));
  assign abort     = (state == RECV) && cs_rise && !last_word;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: the bit on a coincident sclk edge is processed before cs_rise.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = RECV;
      RECV: begin
        if (last_word)    state_nxt = cs_rise ? IDLE : WAIT_CS;
        else if (cs_rise) state_nxt = IDLE;
      end
      WAIT_CS: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift/count datapath and registered output strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      word_cnt    <= '0;
      shift       <= '0;
      insert_data <= 1'b0;
      addr        <= '0;
      data_out    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      insert_data <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= abort;
      if (state == IDLE && cs_fall) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
        shift    <= '0;
      end
      if (state == RECV && sclk_rise) begin
        shift <= {shift[MSB-2:0], mosi_s};
        if (word_done) begin
          bit_cnt     <= '0;
          word_cnt    <= word_cnt + 1'b1;
          insert_data <= 1'b1;
          addr        <= word_cnt;
          data_out    <= {shift[MSB-2:0], mosi_s};
          frame_done  <= last_word;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign busy      = (state == RECV);
  assign dbg_state = state;

endmodule
